sc_image_sequencer: RTL and testbench
=====================================

// Module: sc_image_sequencer
// PURPOSE
//  Parametrised image-index sequencer for the sprite/background display path.
//  Produces image index 0..IMG_LAST, advanced by an internal programmable prescaler.
//  Supports wrap-up, wrap-down, ping-pong and one-shot modes, plus load/clear/hold commands.
//  Sits between the game FSM (drives cmd/mode) and the image ROM address mux.
// PARAMETERS
//  IMG_WIDTH    3   width of image index; IMG_LAST must be < 2**IMG_WIDTH
//  IMG_LAST     7   last valid image index (>= 0)
//  PRESC_WIDTH  22  width of prescaler counter and period input
// PORTS
//  SC_IMAGE_COUNTER_CLOCK_50      in   1            system clock, 50 MHz
//  SC_IMAGE_COUNTER_RESET_InHigh  in   1            reset, asynchronous, active-high
//  SC_IMAGE_SEQ_cmd_InBus         in   2            00 RUN, 01 HOLD, 10 CLEAR, 11 LOAD
//  SC_IMAGE_SEQ_mode_InBus        in   2            00 WRAP_UP, 01 WRAP_DOWN, 10 PINGPONG, 11 ONESHOT
//  SC_IMAGE_SEQ_period_InBus      in   PRESC_WIDTH  advance every period+1 RUN cycles
//  SC_IMAGE_SEQ_load_InBus        in   IMG_WIDTH    value for LOAD
//  SC_IMAGE_SEQ_data_OutBUS       out  IMG_WIDTH    current image index (registered)
//  SC_IMAGE_SEQ_dir_Out           out  1            current direction, 0 = up, 1 = down
//  SC_IMAGE_SEQ_tick_Out          out  1            1-cycle pulse, index advance event
//  SC_IMAGE_SEQ_wrap_Out          out  1            1-cycle pulse on wrap, turnaround or one-shot end
//  SC_IMAGE_SEQ_done_Out          out  1            level; one-shot finished
// BEHAVIOUR
//  - Reset (async): data=0, presc=0, dir=0, tick=0, wrap=0, done=0. All outputs are registered.
//  - Command decode, evaluated every clock edge:
//    - CLEAR: data=0, presc=0, dir=0, done=0.
//    - LOAD: data=min(load, IMG_LAST), presc=0, done=0, dir unchanged.
//    - HOLD: data, presc, dir and done frozen.
//    - RUN: if presc>=period, an advance occurs and presc is set to 0; else presc+1.
//    - Using >= means a period lowered below presc mid-count advances on the next RUN edge.
//    - period=0 advances every RUN cycle.
//  - On an advance, tick=1 for one cycle, aligned with the new data value. tick/wrap are 0 on every non-advance edge.
//  - Advance by mode:
//    - WRAP_UP: dir=0; data+1, or IMG_LAST->0 with wrap=1.
//    - WRAP_DOWN: dir=1; data-1, or 0->IMG_LAST with wrap=1.
//    - PINGPONG, going up: at IMG_LAST -> data=IMG_LAST-1, dir=1, wrap=1.
//    - PINGPONG, going down: at 0 -> data=1, dir=0, wrap=1.
//    - ONESHOT: dir=0; data+1 until IMG_LAST. An advance at IMG_LAST with done=0 sets done=1 and wrap=1.
//    - ONESHOT with done=1: further advances give tick=1, data unchanged, wrap=0.
//  - IMG_LAST=0: data stays 0. Every advance pulses wrap, except ONESHOT after done. dir still updated per mode.
//  - Mode change mid-run: takes effect at the next advance. Current data and presc are kept. PINGPONG keeps the current dir.
//  - Leaving ONESHOT does not clear done; only CLEAR, LOAD or reset clear it.
//  - Arithmetic is IMG_WIDTH-bit and never exceeds IMG_LAST. LOAD clamps out-of-range values.
// TESTING
//  1. Setup: IMG_LAST=7, WRAP_UP, period=0, RUN.
//     -> data 0,1,...,7,0 on consecutive cycles; wrap=1 only on the cycle data=0; tick=1 every cycle.
//  2. period=3, RUN.
//     -> data increments once every 4 cycles; tick is a 1-cycle pulse.
//     -> period set 3->1 while presc=3 -> advance on the next edge.
//  3. PINGPONG, period=0, from 0.
//     -> data 0..7,6,...,0,1.
//     -> dir rises with data=6 and falls with data=1; wrap pulses at both turnarounds.
//  4. ONESHOT, period=0.
//     -> data reaches 7; one cycle later done=1 with a single wrap pulse.
//     -> further RUN keeps data=7 and tick pulsing; CLEAR -> data=0, done=0.
//  5. LOAD:
//     -> LOAD 5 (IMG_LAST=7) -> data=5 next edge, presc=0.
//     -> IMG_LAST=5 build, LOAD 7 -> data=5.
//     -> HOLD for 10 cycles mid-count -> data and presc unchanged, then RUN resumes the count.
//  6. Async reset mid-count (period=3, data=4, dir=1) -> all outputs 0 immediately, before the clock edge.
//     -> after release with RUN: first advance after 4 cycles.

Source files
------------

// File: rtl/sc_image_sequencer.sv
// Image-index sequencer: prescaled advance of an index 0..IMG_LAST in
// wrap-up, wrap-down, ping-pong or one-shot order, with run/hold/clear/load
// commands from the game FSM. Feeds the image ROM address mux.
module sc_image_sequencer #(
  parameter int unsigned IMG_WIDTH   = 3,
  parameter int unsigned IMG_LAST    = 7,
  parameter int unsigned PRESC_WIDTH = 22
) (
  input  logic                   SC_IMAGE_COUNTER_CLOCK_50,
  input  logic                   SC_IMAGE_COUNTER_RESET_InHigh,
  input  logic [1:0]             SC_IMAGE_SEQ_cmd_InBus,
  input  logic [1:0]             SC_IMAGE_SEQ_mode_InBus,
  input  logic [PRESC_WIDTH-1:0] SC_IMAGE_SEQ_period_InBus,
  input  logic [IMG_WIDTH-1:0]   SC_IMAGE_SEQ_load_InBus,
  output logic [IMG_WIDTH-1:0]   SC_IMAGE_SEQ_data_OutBUS,
  output logic                   SC_IMAGE_SEQ_dir_Out,
  output logic                   SC_IMAGE_SEQ_tick_Out,
  output logic                   SC_IMAGE_SEQ_wrap_Out,
  output logic                   SC_IMAGE_SEQ_done_Out
);

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_HOLD  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;
  localparam logic [1:0] CMD_LOAD  = 2'b11;

  localparam logic [1:0] MODE_WRAP_UP   = 2'b00;
  localparam logic [1:0] MODE_WRAP_DOWN = 2'b01;
  localparam logic [1:0] MODE_PINGPONG  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT   = 2'b11;

  // Turnaround targets; a single-image sequence (IMG_LAST=0) stays on 0.
  localparam int unsigned PP_TOP_TURN = (IMG_LAST == 0) ? 0 : IMG_LAST - 1;
  localparam int unsigned PP_BOT_TURN = (IMG_LAST == 0) ? 0 : 1;

  localparam logic [IMG_WIDTH-1:0] LAST_V     = IMG_WIDTH'(IMG_LAST);
  localparam logic [IMG_WIDTH-1:0] TOP_TURN_V = IMG_WIDTH'(PP_TOP_TURN);
  localparam logic [IMG_WIDTH-1:0] BOT_TURN_V = IMG_WIDTH'(PP_BOT_TURN);
  localparam logic [IMG_WIDTH-1:0] ZERO_V     = '0;
  localparam logic [IMG_WIDTH-1:0] ONE_V      = IMG_WIDTH'(1);

  logic [IMG_WIDTH-1:0]   data_q, data_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic                   dir_q, dir_d;
  logic                   tick_q, tick_d;
  logic                   wrap_q, wrap_d;
  logic                   done_q, done_d;
  logic                   adv_c;

  // State register with asynchronous active-high reset.
  always_ff @(posedge SC_IMAGE_COUNTER_CLOCK_50 or posedge SC_IMAGE_COUNTER_RESET_InHigh) begin
    if (SC_IMAGE_COUNTER_RESET_InHigh) begin
      data_q  <= '0;
      presc_q <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  // Command decode, prescaler and per-mode advance (next-state logic).
  always_comb begin
    data_d  = data_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    adv_c   = 1'b0;

    case (SC_IMAGE_SEQ_cmd_InBus)
      CMD_CLEAR: begin
        data_d  = '0;
        presc_d = '0;
        dir_d   = 1'b0;
        done_d  = 1'b0;
      end
      CMD_LOAD: begin
        data_d  = (SC_IMAGE_SEQ_load_InBus > LAST_V) ? LAST_V : SC_IMAGE_SEQ_load_InBus;
        presc_d = '0;
        done_d  = 1'b0;
      end
      CMD_HOLD: begin
      end
      CMD_RUN: begin
        // >= so a period lowered below the running count fires immediately.
        if (presc_q >= SC_IMAGE_SEQ_period_InBus) begin
          presc_d = '0;
          adv_c   = 1'b1;
        end else begin
          presc_d = presc_q + PRESC_WIDTH'(1);
        end
      end
      default: begin
      end
    endcase

    if (adv_c) begin
      tick_d = 1'b1;
      case (SC_IMAGE_SEQ_mode_InBus)
        MODE_WRAP_UP: begin
          dir_d = 1'b0;
          if (data_q >= LAST_V) begin
            data_d = ZERO_V;
            wrap_d = 1'b1;
          end else begin
            data_d = data_q + ONE_V;
          end
        end
        MODE_WRAP_DOWN: begin
          dir_d = 1'b1;
          if (data_q == ZERO_V) begin
            data_d = LAST_V;
            wrap_d = 1'b1;
          end else begin
            data_d = data_q - ONE_V;
          end
        end
        MODE_PINGPONG: begin
          if (!dir_q) begin
            if (data_q >= LAST_V) begin
              data_d = TOP_TURN_V;
              dir_d  = 1'b1;
              wrap_d = 1'b1;
            end else begin
              data_d = data_q + ONE_V;
            end
          end else begin
            if (data_q == ZERO_V) begin
              data_d = BOT_TURN_V;
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end else begin
              data_d = data_q - ONE_V;
            end
          end
        end
        MODE_ONESHOT: begin
          dir_d = 1'b0;
          if (!done_q) begin
            if (data_q >= LAST_V) begin
              done_d = 1'b1;
              wrap_d = 1'b1;
            end else begin
              data_d = data_q + ONE_V;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign SC_IMAGE_SEQ_data_OutBUS = data_q;
  assign SC_IMAGE_SEQ_dir_Out     = dir_q;
  assign SC_IMAGE_SEQ_tick_Out    = tick_q;
  assign SC_IMAGE_SEQ_wrap_Out    = wrap_q;
  assign SC_IMAGE_SEQ_done_Out    = done_q;

endmodule

// File: tb/tb_sc_image_sequencer.sv
// Bench for sc_image_sequencer: directed stimulus pushes hand-computed
// advance results into a scoreboard; a monitor pops one per tick pulse.
module tb_sc_image_sequencer;

  localparam logic [1:0] RUN = 2'b00, HOLD = 2'b01, CLEAR = 2'b10, LOAD = 2'b11;
  localparam logic [1:0] WUP = 2'b00, WDN = 2'b01, PP = 2'b10, ONE = 2'b11;

  typedef struct packed {
    logic [2:0] data;
    logic       dir;
    logic       wrap;
    logic       done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd = CLEAR;
  logic [1:0]  mode = WUP;
  logic [21:0] period = '0;
  logic [2:0]  load = '0;

  logic [2:0] d0, d1, d2;
  logic       dir0, dir1, dir2, tk0, tk1, tk2, wr0, wr1, wr2, dn0, dn1, dn2;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sc_image_sequencer #(.IMG_WIDTH(3), .IMG_LAST(7), .PRESC_WIDTH(22)) dut0 (
    .SC_IMAGE_COUNTER_CLOCK_50(clk), .SC_IMAGE_COUNTER_RESET_InHigh(rst),
    .SC_IMAGE_SEQ_cmd_InBus(cmd), .SC_IMAGE_SEQ_mode_InBus(mode),
    .SC_IMAGE_SEQ_period_InBus(period), .SC_IMAGE_SEQ_load_InBus(load),
    .SC_IMAGE_SEQ_data_OutBUS(d0), .SC_IMAGE_SEQ_dir_Out(dir0),
    .SC_IMAGE_SEQ_tick_Out(tk0), .SC_IMAGE_SEQ_wrap_Out(wr0), .SC_IMAGE_SEQ_done_Out(dn0));

  sc_image_sequencer #(.IMG_WIDTH(3), .IMG_LAST(5), .PRESC_WIDTH(22)) dut1 (
    .SC_IMAGE_COUNTER_CLOCK_50(clk), .SC_IMAGE_COUNTER_RESET_InHigh(rst),
    .SC_IMAGE_SEQ_cmd_InBus(cmd), .SC_IMAGE_SEQ_mode_InBus(mode),
    .SC_IMAGE_SEQ_period_InBus(period), .SC_IMAGE_SEQ_load_InBus(load),
    .SC_IMAGE_SEQ_data_OutBUS(d1), .SC_IMAGE_SEQ_dir_Out(dir1),
    .SC_IMAGE_SEQ_tick_Out(tk1), .SC_IMAGE_SEQ_wrap_Out(wr1), .SC_IMAGE_SEQ_done_Out(dn1));

  sc_image_sequencer #(.IMG_WIDTH(3), .IMG_LAST(0), .PRESC_WIDTH(22)) dut2 (
    .SC_IMAGE_COUNTER_CLOCK_50(clk), .SC_IMAGE_COUNTER_RESET_InHigh(rst),
    .SC_IMAGE_SEQ_cmd_InBus(cmd), .SC_IMAGE_SEQ_mode_InBus(mode),
    .SC_IMAGE_SEQ_period_InBus(period), .SC_IMAGE_SEQ_load_InBus(load),
    .SC_IMAGE_SEQ_data_OutBUS(d2), .SC_IMAGE_SEQ_dir_Out(dir2),
    .SC_IMAGE_SEQ_tick_Out(tk2), .SC_IMAGE_SEQ_wrap_Out(wr2), .SC_IMAGE_SEQ_done_Out(dn2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_adv(input logic [2:0] d, input logic dr, input logic w, input logic dn);
    exp_t e;
    e = {d, dr, w, dn};
    sb.push_back(e);
  endtask

  // One clock edge with the given command; returns 1 time unit after the edge.
  task automatic step(input logic [1:0] c);
    cmd = c;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every tick pops one expected advance; wrap must never pulse alone.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tk0 === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_tick", 32'(d0), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("adv_data", 32'(d0), 32'(e.data));
          chk("adv_dir",  32'(dir0), 32'(e.dir));
          chk("adv_wrap", 32'(wr0), 32'(e.wrap));
          chk("adv_done", 32'(dn0), 32'(e.done));
        end
      end else begin
        chk("wrap_without_tick", 32'(wr0), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] pp_data [16];
    logic       pp_dir  [16];

    // Reset state
    @(posedge clk); #1;
    chk("rst_data", 32'(d0), 32'd0);
    chk("rst_dir",  32'(dir0), 32'd0);
    chk("rst_tick", 32'(tk0), 32'd0);
    chk("rst_wrap", 32'(wr0), 32'd0);
    chk("rst_done", 32'(dn0), 32'd0);
    rst = 1'b0;

    // 1: WRAP_UP, period 0 -> 1..7,0,1 ; wrap only on 0
    mode = WUP; period = 22'd0;
    for (int i = 1; i <= 9; i++) begin
      expect_adv(3'(i % 8), 1'b0, (i == 8), 1'b0);
      step(RUN);
      chk("l0_data", 32'(d2), 32'd0);
      chk("l0_wrap", 32'(wr2), 32'd1);
    end
    step(CLEAR);
    chk("clear_data", 32'(d0), 32'd0);

    // 2: period 3 -> advance every 4th edge; then lower period at presc=3
    period = 22'd3;
    for (int a = 1; a <= 2; a++) begin
      repeat (3) step(RUN);
      expect_adv(3'(a), 1'b0, 1'b0, 1'b0);
      step(RUN);
    end
    repeat (3) step(RUN);
    period = 22'd1;
    expect_adv(3'd3, 1'b0, 1'b0, 1'b0);
    step(RUN);
    step(RUN);
    expect_adv(3'd4, 1'b0, 1'b0, 1'b0);
    step(RUN);

    // 3: PINGPONG from 0
    step(CLEAR);
    pp_data = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    pp_dir  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    mode = PP; period = 22'd0;
    for (int i = 0; i < 16; i++) begin
      expect_adv(pp_data[i], pp_dir[i], (i == 7) || (i == 14), 1'b0);
      step(RUN);
    end

    // 4: ONESHOT
    step(CLEAR);
    mode = ONE;
    for (int i = 1; i <= 7; i++) begin
      expect_adv(3'(i), 1'b0, 1'b0, 1'b0);
      step(RUN);
      if (i == 1) begin
        chk("l0_one_done", 32'(dn2), 32'd1);
        chk("l0_one_wrap", 32'(wr2), 32'd1);
      end
      if (i == 2) begin
        chk("l0_one_after_wrap", 32'(wr2), 32'd0);
        chk("l0_one_after_tick", 32'(tk2), 32'd1);
      end
    end
    expect_adv(3'd7, 1'b0, 1'b1, 1'b1);
    step(RUN);
    repeat (2) begin
      expect_adv(3'd7, 1'b0, 1'b0, 1'b1);
      step(RUN);
    end
    mode = WUP;
    expect_adv(3'd0, 1'b0, 1'b1, 1'b1);
    step(RUN);
    step(CLEAR);
    chk("os_clear_data", 32'(d0), 32'd0);
    chk("os_clear_done", 32'(dn0), 32'd0);
    chk("os_clear_done_l0", 32'(dn2), 32'd0);

    // 5: LOAD with clamp, then HOLD mid-count
    load = 3'd7;
    step(LOAD);
    chk("load7_l7", 32'(d0), 32'd7);
    chk("load7_l5_clamp", 32'(d1), 32'd5);
    chk("load_tick", 32'(tk0), 32'd0);
    load = 3'd5;
    step(LOAD);
    chk("load5", 32'(d0), 32'd5);
    period = 22'd3;
    repeat (2) step(RUN);
    for (int i = 0; i < 10; i++) begin
      step(HOLD);
      chk("hold_data", 32'(d0), 32'd5);
    end
    step(RUN);
    expect_adv(3'd6, 1'b0, 1'b0, 1'b0);
    step(RUN);

    // 6: async reset mid-count with data=4, dir=1
    step(LOAD);
    mode = WDN;
    repeat (3) step(RUN);
    expect_adv(3'd4, 1'b1, 1'b0, 1'b0);
    step(RUN);
    repeat (2) step(RUN);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data", 32'(d0), 32'd0);
    chk("arst_dir",  32'(dir0), 32'd0);
    chk("arst_tick", 32'(tk0), 32'd0);
    chk("arst_wrap", 32'(wr0), 32'd0);
    chk("arst_done", 32'(dn0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mode = WUP;
    repeat (3) step(RUN);
    expect_adv(3'd1, 1'b0, 1'b0, 1'b0);
    step(RUN);

    step(HOLD);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
